// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder built around a single full-adder cell
//
// full_adder : 1-bit combinational full adder
//   sum, cout : outputs; a, b, cin : inputs
//
// serial_adder : LSB-first bit-serial adder with registered carry
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : request pulse, sampled only in IDLE
//   a, b   : operands, captured on the accepting edge
//   busy   : high while bits are being processed
//   done   : one-cycle pulse, sum/cout valid
//   sum    : a+b mod 2^WIDTH, held until the next accepted start
//   cout   : carry out of bit WIDTH-1, held with sum
//   WIDTH legal range is 2..32

module full_adder (
  output logic sum,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;

  full_adder u_fa (
    .sum  (fa_sum),
    .cout (fa_cout),
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            sa    <= a;
            sb    <= b;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          // Result bits enter at the MSB and walk down, so after WIDTH
          // shifts bit 0 of the result sits in sum[0].
          sum   <= {fa_sum, sum[WIDTH-1:1]};
          carry <= fa_cout;
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            cout  <= fa_cout;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          // start is deliberately not looked at here; it is not queued.
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (WIDTH=8 and WIDTH=4)
module tb_serial_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done4  = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  always @(negedge clk) if (rst_n && done4) n_done4++;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       c;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run8(input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] es, input logic ec, input string name);
    int e;
    int bcnt;
    @(negedge clk);
    a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk);
    e = 0; bcnt = 0;
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~x; b8 = ~y;
    while (!done8 && e < 20) begin
      if (busy8) bcnt++;
      @(posedge clk); e++;
      @(negedge clk);
    end
    check({name, " latency"}, e, 8);
    check({name, " busy_cycles"}, bcnt, 8);
    check({name, " sum"}, sum8, es);
    check({name, " cout"}, cout8, ec);
    @(negedge clk);
    check({name, " done_width"}, done8, 1'b0);
  endtask

  task automatic run4(input logic [3:0] x, input logic [3:0] y);
    int e;
    logic [4:0] exp;
    exp = {1'b0, x} + {1'b0, y};
    @(negedge clk);
    a4 = x; b4 = y; start4 = 1'b1;
    @(posedge clk);
    e = 0;
    @(negedge clk);
    start4 = 1'b0;
    while (!done4 && e < 12) begin
      @(posedge clk); e++;
      @(negedge clk);
    end
    check($sformatf("w4 %0h+%0h latency", x, y), e, 4);
    check($sformatf("w4 %0h+%0h result", x, y), {cout4, sum4}, exp);
  endtask

  initial begin
    int dcnt;
    int e;
    int k;
    int de[3];
    logic [7:0] oa[3];
    logic [7:0] ob[3];
    logic [7:0] os[3];
    logic       oc[3];

    vecs[0] = '{8'h5A, 8'h3C, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[4] = '{8'h10, 8'h20, 8'h30, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 8'h00, 1'b1};
    vecs[6] = '{8'h7F, 8'h01, 8'h80, 1'b0};
    vecs[7] = '{8'hAA, 8'h55, 8'hFF, 1'b0};
    vecs[8] = '{8'hC3, 8'h3D, 8'h00, 1'b1};
    vecs[9] = '{8'h01, 8'h02, 8'h03, 1'b0};

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(negedge clk);
    check("reset busy", busy8, 1'b0);
    check("reset done", done8, 1'b0);
    check("reset sum", sum8, 8'h00);
    check("reset cout", cout8, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run8(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, $sformatf("vec%0d", i));

    // start pulses during RUN are ignored
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    dcnt = 0;
    for (int c = 1; c <= 14; c++) begin
      start8 = (c == 3 || c == 7);
      @(posedge clk);
      @(negedge clk);
      if (done8) begin
        dcnt++;
        check("ignore_start sum", sum8, 8'h30);
      end
    end
    start8 = 1'b0;
    check("ignore_start done_count", dcnt, 1);

    // start held high: back-to-back runs every WIDTH+2 edges
    oa[0] = 8'h12; ob[0] = 8'h34; os[0] = 8'h46; oc[0] = 1'b0;
    oa[1] = 8'hF0; ob[1] = 8'h20; os[1] = 8'h10; oc[1] = 1'b1;
    oa[2] = 8'h80; ob[2] = 8'h7F; os[2] = 8'hFF; oc[2] = 1'b0;
    @(negedge clk);
    a8 = oa[0]; b8 = ob[0]; start8 = 1'b1;
    @(posedge clk);
    e = 0; k = 0;
    while (k < 3 && e < 60) begin
      @(negedge clk);
      if (done8) begin
        de[k] = e;
        check($sformatf("b2b%0d sum", k), sum8, os[k]);
        check($sformatf("b2b%0d cout", k), cout8, oc[k]);
        k++;
        if (k < 3) begin a8 = oa[k]; b8 = ob[k]; end
      end
      if (k == 2 && busy8) start8 = 1'b0;
      @(posedge clk); e++;
    end
    start8 = 1'b0;
    check("b2b done_count", k, 3);
    if (k == 3) begin
      check("b2b first_done_edge", de[0], 8);
      check("b2b spacing01", de[1] - de[0], 10);
      check("b2b spacing12", de[2] - de[1], 10);
    end
    repeat (3) @(negedge clk);

    // asynchronous reset in the middle of a run
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("midrun busy", busy8, 1'b1);
    check("midrun partial_sum", sum8, 8'hE0);
    rst_n = 1'b0;
    #1;
    check("async_reset busy", busy8, 1'b0);
    check("async_reset done", done8, 1'b0);
    check("async_reset sum", sum8, 8'h00);
    check("async_reset cout", cout8, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) dcnt++;
    end
    check("after_reset no_done", dcnt, 0);
    run8(8'h01, 8'h02, 8'h03, 1'b0, "post_reset");

    // WIDTH=4 exhaustive
    n_done4 = 0;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        run4(i[3:0], j[3:0]);
    repeat (4) @(negedge clk);
    check("w4 done_count", n_done4, 256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end
endmodule
